// File: rtl/lif_pkg.sv
// Shared types for the LIF neuron layer.
//   lif_state_t : controller states (IDLE, CALC, HOLD)
//   LIF_HARD    : after a spike the membrane potential restarts from zero
//   LIF_SOFT    : after a spike the threshold is subtracted from the potential
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } lif_state_t;

  localparam logic LIF_HARD = 1'b0;
  localparam logic LIF_SOFT = 1'b1;

endpackage

// File: rtl/lif_step.sv
// One timestep of a single leaky integrate-and-fire neuron (purely combinational).
// Ports:
//   v         in  Q  current membrane potential
//   cur       in  Q  input current for this step
//   threshold in  Q  firing threshold (fires when the sum strictly exceeds it)
//   mode      in  1  LIF_HARD / LIF_SOFT post-spike behaviour
//   v_next    out Q  membrane potential after this step
//   spike     out 1  spike for this step
module lif_step
  import lif_pkg::*;
#(
  parameter int Q          = 10,
  parameter int LEAK_SHIFT = 0
) (
  input  logic [Q-1:0] v,
  input  logic [Q-1:0] cur,
  input  logic [Q-1:0] threshold,
  input  logic         mode,
  output logic [Q-1:0] v_next,
  output logic         spike
);

  logic [Q-1:0] v_leak;
  logic [Q:0]   sum;
  logic [Q-1:0] s_sat;

  always_comb begin
    // A zero shift would leak the whole potential, so zero means "no leak".
    if (LEAK_SHIFT == 0) v_leak = v;
    else                 v_leak = v - (v >> LEAK_SHIFT);

    // One extra bit catches the carry; saturate instead of wrapping.
    sum   = {1'b0, v_leak} + {1'b0, cur};
    s_sat = sum[Q] ? '1 : sum[Q-1:0];

    spike = (s_sat > threshold);

    if (!spike)                v_next = s_sat;
    else if (mode == LIF_SOFT) v_next = s_sat - threshold;
    else                       v_next = '0;
  end

endmodule

// File: rtl/lif_neuron_array.sv
// N-channel leaky integrate-and-fire layer. A transaction carries N x T input
// currents; all channels integrate in parallel, one timestep per clock, and the
// N x T spike bits are held until the downstream side accepts them.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   input handshake; in_data current (c,t) at [(c*T+t)*Q +: Q]
//   threshold        firing threshold, captured on the input handshake
//   soft_reset_mode  0: V<=0 after spike, 1: V<=V-threshold; captured on handshake
//   out_valid/ready  output handshake; spike_out bit c*T+t is spike for (c,t)
//   busy             high while timesteps are being computed
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N          = 4,
  parameter int T          = 8,
  parameter int Q          = 10,
  parameter int LEAK_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*T*Q-1:0] in_data,
  input  logic [Q-1:0]     threshold,
  input  logic             soft_reset_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*T-1:0]   spike_out,
  output logic             busy
);

  localparam int CW = (T > 1) ? $clog2(T) : 1;

  lif_state_t       state;
  logic [CW-1:0]    step;
  logic [N*T*Q-1:0] data_q;
  logic [Q-1:0]     thr_q;
  logic             mode_q;
  logic [Q-1:0]     v_q   [N];
  logic [Q-1:0]     v_nxt [N];
  logic [Q-1:0]     cur   [N];
  logic [N-1:0]     spk;
  logic             accept;

  // Accepting while in HOLD lets the result leave and a new job enter on one edge.
  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int c = 0; c < N; c++) begin
      cur[c] = data_q[(c*T + int'(step))*Q +: Q];
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_ch
    lif_step #(.Q(Q), .LEAK_SHIFT(LEAK_SHIFT)) u_step (
      .v         (v_q[c]),
      .cur       (cur[c]),
      .threshold (thr_q),
      .mode      (mode_q),
      .v_next    (v_nxt[c]),
      .spike     (spk[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= '0;
      data_q    <= '0;
      thr_q     <= '0;
      mode_q    <= LIF_HARD;
      spike_out <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int c = 0; c < N; c++) v_q[c] <= '0;
    end else if (accept) begin
      state     <= CALC;
      step      <= '0;
      data_q    <= in_data;
      thr_q     <= threshold;
      mode_q    <= soft_reset_mode;
      spike_out <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
      for (int c = 0; c < N; c++) v_q[c] <= '0;
    end else begin
      case (state)
        CALC: begin
          for (int c = 0; c < N; c++) begin
            v_q[c]                        <= v_nxt[c];
            spike_out[c*T + int'(step)]   <= spk[c];
          end
          if (step == CW'(T-1)) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            step <= step + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array: two instances (no leak, LEAK_SHIFT=1),
// directed transactions with hand-derived spike patterns.
module tb_lif_neuron_array;
  import lif_pkg::*;

  localparam int N = 2;
  localparam int T = 8;
  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid, out_ready, in_ready, out_valid, busy;
  logic [N*T*Q-1:0] in_data;
  logic [Q-1:0]     threshold;
  logic             soft_reset_mode;
  logic [N*T-1:0]   spike_out;

  logic             in_valid_l, out_ready_l, in_ready_l, out_valid_l, busy_l;
  logic [N*T-1:0]   spike_out_l;

  int tests = 0;
  int fails = 0;
  logic [N*T-1:0] sb[$];
  logic [N*T-1:0] sb_l[$];

  lif_neuron_array #(.N(N), .T(T), .Q(Q), .LEAK_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .threshold(threshold), .soft_reset_mode(soft_reset_mode),
    .out_valid(out_valid), .out_ready(out_ready), .spike_out(spike_out), .busy(busy)
  );

  lif_neuron_array #(.N(N), .T(T), .Q(Q), .LEAK_SHIFT(1)) dut_leak (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_l), .in_ready(in_ready_l),
    .in_data(in_data), .threshold(threshold), .soft_reset_mode(soft_reset_mode),
    .out_valid(out_valid_l), .out_ready(out_ready_l), .spike_out(spike_out_l), .busy(busy_l)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N*T*Q-1:0] pack(logic [Q-1:0] a, logic [Q-1:0] b);
    logic [N*T*Q-1:0] r;
    r = '0;
    for (int t = 0; t < T; t++) begin
      r[t*Q +: Q]     = a;
      r[(T+t)*Q +: Q] = b;
    end
    return r;
  endfunction

  // Monitors: compare on every output handshake, sampled after negedge writes settle.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: got 0x%0h expected none", spike_out);
      end else begin
        check("spikes", 32'(spike_out), 32'(sb.pop_front()));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid_l && out_ready_l) begin
      if (sb_l.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output_leak: got 0x%0h expected none", spike_out_l);
      end else begin
        check("spikes_leak", 32'(spike_out_l), 32'(sb_l.pop_front()));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(logic [Q-1:0] a, logic [Q-1:0] b, logic [Q-1:0] thr,
                      logic mode, logic [N*T-1:0] exp);
    int k;
    in_data = pack(a, b);
    threshold = thr;
    soft_reset_mode = mode;
    in_valid = 1'b1;
    k = 0;
    #1;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    // Post-accept input changes must not affect the running job.
    in_data = '1;
    threshold = '0;
    soft_reset_mode = ~mode;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    in_valid = 0; out_ready = 1; in_valid_l = 0; out_ready_l = 1;
    in_data = '0; threshold = '0; soft_reset_mode = LIF_HARD;

    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_spike_out", 32'(spike_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(10'd60, 10'd0, 10'd100, LIF_HARD, 16'h00AA);   drain();
    send(10'd60, 10'd0, 10'd100, LIF_SOFT, 16'h006A);   drain();
    send(10'd600, 10'd600, 10'd1023, LIF_HARD, 16'h0000); drain();
    check("sat_v_ch0", 32'(dut.v_q[0]), 1023);
    check("sat_v_ch1", 32'(dut.v_q[1]), 1023);
    send(10'd0, 10'd1, 10'd0, LIF_HARD, 16'hFF00);      drain();

    // Leaky instance: V goes 60, 90, 105(fire) ...
    @(negedge clk);
    in_data = pack(10'd60, 10'd0); threshold = 10'd100; soft_reset_mode = LIF_HARD;
    in_valid_l = 1'b1;
    #1;
    check("leak_in_ready", 32'(in_ready_l), 1);
    @(posedge clk);
    sb_l.push_back(16'h0024);
    @(negedge clk);
    in_valid_l = 1'b0;
    n = 0;
    while (sb_l.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("leak_drained", 32'(sb_l.size()), 0);

    // Back-pressure, then simultaneous output and input handshakes.
    out_ready = 1'b0;
    send(10'd60, 10'd0, 10'd100, LIF_HARD, 16'h00AA);
    n = 0;
    while (!out_valid && n < 30) begin @(negedge clk); n++; end
    check("bp_out_valid_rise", 32'(out_valid), 1);
    repeat (5) begin
      #1;
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_spike_out", 32'(spike_out), 32'h00AA);
      check("bp_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(10'd60, 10'd60, 10'd100, LIF_SOFT, 16'h6A6A);
    check("b2b_out_valid", 32'(out_valid), 0);
    check("b2b_busy", 32'(busy), 1);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!out_valid && n < 20);
    check("latency_edges", 32'(n), T);
    drain();

    // Abort mid-calculation.
    send(10'd60, 10'd0, 10'd100, LIF_HARD, 16'h00AA);
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_spike_out", 32'(spike_out), 0);
    check("abort_busy", 32'(busy), 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    send(10'd60, 10'd0, 10'd100, LIF_SOFT, 16'h006A);   drain();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
